multi_timer: RTL and testbench

Parametrised bank of independent down-counting timers. Each channel can be loaded as a one-shot or periodic timer, paused, or cancelled, and reports busy, a one-cycle expiry pulse and a sticky pending flag. The flags are OR-reduced into a single interrupt line. The block sits alongside control/sequencing logic that needs several concurrent cycle-accurate delays from one instance.

---
 rtl/multi_timer.sv | 90 +++++++++
 tb/tb_multi_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// Bank of independent down-counting timers with one-shot/periodic reload,
// per-channel pause/stop, a one-cycle expiry pulse and a sticky pending flag.
module multi_timer #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 4,
   localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [CW-1:0]       load_ch,
   input  logic [WIDTH-1:0]    load_cycles,
   input  logic                load_periodic,
   input  logic [CHANNELS-1:0] stop,
   input  logic [CHANNELS-1:0] pause,
   input  logic [CHANNELS-1:0] ack,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] done,
   output logic [CHANNELS-1:0] pending,
   output logic                irq
);

   logic [WIDTH-1:0]    counter_q [CHANNELS];
   logic [WIDTH-1:0]    counter_d [CHANNELS];
   logic [WIDTH-1:0]    reload_q  [CHANNELS];
   logic [WIDTH-1:0]    reload_d  [CHANNELS];
   logic [CHANNELS-1:0] periodic_q;
   logic [CHANNELS-1:0] periodic_d;
   logic [CHANNELS-1:0] done_d;
   logic [CHANNELS-1:0] pending_d;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            counter_q[i] <= '0;
            reload_q[i]  <= '0;
         end
         periodic_q <= '0;
         done       <= '0;
         pending    <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            counter_q[i] <= counter_d[i];
            reload_q[i]  <= reload_d[i];
         end
         periodic_q <= periodic_d;
         done       <= done_d;
         pending    <= pending_d;
      end
   end

   // Per-channel next state: load > stop > pause > count
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         counter_d[i]  = counter_q[i];
         reload_d[i]   = reload_q[i];
         periodic_d[i] = periodic_q[i];
         done_d[i]     = 1'b0;
         pending_d[i]  = pending[i] & ~ack[i];

         if (load && (load_ch == CW'(i))) begin
            counter_d[i]  = load_cycles;
            reload_d[i]   = load_cycles;
            periodic_d[i] = load_periodic && (load_cycles != '0);
         end else if (stop[i]) begin
            counter_d[i]  = '0;
            periodic_d[i] = 1'b0;
         end else if (!pause[i]) begin
            if (counter_q[i] > WIDTH'(1)) begin
               counter_d[i] = counter_q[i] - WIDTH'(1);
            end else if (counter_q[i] == WIDTH'(1)) begin
               // Expiry wins over a same-cycle ack so the event is never lost
               counter_d[i] = periodic_q[i] ? reload_q[i] : '0;
               done_d[i]    = 1'b1;
               pending_d[i] = 1'b1;
            end
         end
      end
   end

   // Status derived directly from state
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         busy[i] = (counter_q[i] != '0);
      end
      irq = |pending;
   end

endmodule

// File: tb/tb_multi_timer.sv
// Randomised scoreboard bench for multi_timer against a deadline-based timing model.
module tb_multi_timer;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NCH   = 5;
   localparam int unsigned CW    = 3;

   typedef struct packed {
      logic [NCH-1:0] busy;
      logic [NCH-1:0] done;
      logic [NCH-1:0] pending;
      logic           irq;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             load;
   logic [CW-1:0]    load_ch;
   logic [WIDTH-1:0] load_cycles;
   logic             load_periodic;
   logic [NCH-1:0]   stop;
   logic [NCH-1:0]   pause;
   logic [NCH-1:0]   ack;
   logic [NCH-1:0]   busy;
   logic [NCH-1:0]   done;
   logic [NCH-1:0]   pending;
   logic             irq;

   int checks   = 0;
   int failures = 0;
   exp_t exp_q[$];

   multi_timer #(.WIDTH(WIDTH), .CHANNELS(NCH)) dut (
      .clk(clk), .reset(reset), .load(load), .load_ch(load_ch),
      .load_cycles(load_cycles), .load_periodic(load_periodic),
      .stop(stop), .pause(pause), .ack(ack),
      .busy(busy), .done(done), .pending(pending), .irq(irq)
   );

   always #5 clk = ~clk;

   // Model: each active channel has an absolute cycle at which done fires
   longint         cyc = 0;
   longint         expire_at [NCH];
   int             period    [NCH];
   logic [NCH-1:0] m_act  = '0;
   logic [NCH-1:0] m_per  = '0;
   logic [NCH-1:0] m_pend = '0;
   logic [NCH-1:0] m_done = '0;

   task automatic step(input bit rst, input bit ld, input int ldch, input int n,
                       input bit lp, input logic [NCH-1:0] stp,
                       input logic [NCH-1:0] pse, input logic [NCH-1:0] ak);
      exp_t e;
      reset         = rst;
      load          = ld;
      load_ch       = CW'(ldch);
      load_cycles   = WIDTH'(n);
      load_periodic = lp;
      stop          = stp;
      pause         = pse;
      ack           = ak;
      for (int i = 0; i < NCH; i++) begin
         if (rst) begin
            m_act[i] = 1'b0; m_per[i] = 1'b0; m_pend[i] = 1'b0; m_done[i] = 1'b0;
         end else begin
            m_done[i] = 1'b0;
            m_pend[i] = m_pend[i] && !ak[i];
            if (ld && ldch == i) begin
               if (n == 0) begin
                  m_act[i] = 1'b0;
               end else begin
                  m_act[i]     = 1'b1;
                  expire_at[i] = cyc + 1 + longint'(n);
                  period[i]    = n;
                  m_per[i]     = lp;
               end
            end else if (stp[i]) begin
               m_act[i] = 1'b0;
            end else if (m_act[i] && pse[i]) begin
               expire_at[i] = expire_at[i] + 1;
            end else if (m_act[i] && expire_at[i] == cyc + 1) begin
               m_done[i] = 1'b1;
               m_pend[i] = 1'b1;
               if (m_per[i]) expire_at[i] = cyc + 1 + longint'(period[i]);
               else          m_act[i]     = 1'b0;
            end
         end
      end
      cyc = cyc + 1;
      e.busy    = m_act;
      e.done    = m_done;
      e.pending = m_pend;
      e.irq     = |m_pend;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic idle(input int cycles);
      for (int c = 0; c < cycles; c++) step(0, 0, 0, 0, 0, '0, '0, '0);
   endtask

   // Monitor: compare every cycle's outputs against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({busy, done, pending, irq} !== e) begin
               failures++;
               $display("FAIL outputs t=%0t got busy=%b done=%b pending=%b irq=%b want busy=%b done=%b pending=%b irq=%b",
                        $time, busy, done, pending, irq, e.busy, e.done, e.pending, e.irq);
            end
         end
      end
   end

   initial begin
      logic [NCH-1:0] stp, pse, ak;
      int n;
      step(1, 0, 0, 0, 0, '0, '0, '0);
      step(1, 0, 0, 0, 0, '0, '0, '0);
      idle(1);
      // one-shot N=5 on ch0, then ack
      step(0, 1, 0, 5, 0, '0, '0, '0);
      idle(8);
      step(0, 0, 0, 0, 0, '0, '0, 5'b00001);
      idle(2);
      // periodic N=3 on ch1, then stop
      step(0, 1, 1, 3, 1, '0, '0, '0);
      idle(10);
      step(0, 0, 0, 0, 0, 5'b00010, '0, '0);
      idle(5);
      // ch2 N=4 with 3-cycle pause after first decrement
      step(0, 1, 2, 4, 0, '0, '0, '0);
      idle(1);
      for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0, '0, 5'b00100, '0);
      idle(6);
      // zero load and out-of-range channel indices
      step(0, 1, 3, 0, 1, '0, '0, '0);
      idle(2);
      step(0, 1, 5, 7, 0, '0, '0, '0);
      step(0, 1, 7, 2, 1, '0, '0, '0);
      idle(3);
      // ack coinciding with expiry, then ack after
      step(0, 1, 0, 2, 0, '0, '0, '0);
      idle(1);
      step(0, 0, 0, 0, 0, '0, '0, 5'b11111);
      step(0, 0, 0, 0, 0, '0, '0, 5'b11111);
      idle(2);
      // periodic N=1 and load overriding stop/pause
      step(0, 1, 4, 1, 1, 5'b10000, 5'b10000, '0);
      idle(4);
      step(0, 1, 4, 3, 0, 5'b10000, 5'b10000, '0);
      step(0, 0, 0, 0, 0, '0, 5'b10000, '0);
      idle(5);
      // long load, reset mid-count
      step(0, 1, 0, 16'hFFFF, 0, '0, '0, '0);
      idle(100);
      step(1, 0, 0, 0, 0, '0, '0, '0);
      idle(3);
      // random traffic
      for (int t = 0; t < 3000; t++) begin
         stp = '0; pse = '0; ak = '0;
         for (int i = 0; i < NCH; i++) begin
            stp[i] = ($urandom_range(0, 29) == 0);
            pse[i] = ($urandom_range(0, 4) == 0);
            ak[i]  = ($urandom_range(0, 3) == 0);
         end
         n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 8));
         step(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) == 0),
              int'($urandom_range(0, 7)), n, 1'($urandom_range(0, 1)), stp, pse, ak);
      end
      idle(2);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain leftover=%0d want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
